// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ID/EX register, ALU, EX forwarding bus,
// and the EX/MEM register that also feeds the MEM forwarding bus.
module ex_stage #(
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ALUOP_W-1:0]  aluop_i,
    input  logic [ALUSEL_W-1:0] alusel_i,
    input  logic [31:0]         rdata1_i,
    input  logic [31:0]         rdata2_i,
    input  logic [4:0]          waddr_i,
    input  logic                we_i,
    input  logic                id_stall_i,
    input  logic                ex_stall_i,
    output logic [4:0]          ex_waddr_o,
    output logic                ex_we_o,
    output logic [31:0]         ex_wdata_o,
    output logic [4:0]          mem_waddr_o,
    output logic                mem_we_o,
    output logic [31:0]         mem_wdata_o,
    output logic                ovf_o
);

    localparam logic [ALUSEL_W-1:0] ALUSEL_NOP   = 3'b000;
    localparam logic [ALUSEL_W-1:0] ALUSEL_LOGIC = 3'b001;
    localparam logic [ALUSEL_W-1:0] ALUSEL_SHIFT = 3'b010;
    localparam logic [ALUSEL_W-1:0] ALUSEL_ARITH = 3'b100;

    localparam logic [ALUOP_W-1:0] ALUOP_NOP  = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] ALUOP_AND  = 8'b0010_0100;
    localparam logic [ALUOP_W-1:0] ALUOP_OR   = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] ALUOP_XOR  = 8'b0010_0110;
    localparam logic [ALUOP_W-1:0] ALUOP_NOR  = 8'b0010_0111;
    localparam logic [ALUOP_W-1:0] ALUOP_SLL  = 8'b0111_1100;
    localparam logic [ALUOP_W-1:0] ALUOP_SRL  = 8'b0000_0010;
    localparam logic [ALUOP_W-1:0] ALUOP_SRA  = 8'b0000_0011;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 8'b0010_0000;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDU = 8'b0010_0001;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 8'b0010_0010;
    localparam logic [ALUOP_W-1:0] ALUOP_SUBU = 8'b0010_0011;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT  = 8'b0010_1010;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTU = 8'b0010_1011;

    logic [ALUOP_W-1:0]  idex_aluop;
    logic [ALUSEL_W-1:0] idex_alusel;
    logic [31:0]         idex_a;
    logic [31:0]         idex_b;
    logic [4:0]          idex_waddr;
    logic                idex_we;

    // Hold beats bubble so a simultaneous id/ex stall never loses the held instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_aluop  <= ALUOP_NOP;
            idex_alusel <= ALUSEL_NOP;
            idex_a      <= '0;
            idex_b      <= '0;
            idex_waddr  <= '0;
            idex_we     <= 1'b0;
        end else if (ex_stall_i) begin
            idex_aluop  <= idex_aluop;
            idex_alusel <= idex_alusel;
            idex_a      <= idex_a;
            idex_b      <= idex_b;
            idex_waddr  <= idex_waddr;
            idex_we     <= idex_we;
        end else if (id_stall_i) begin
            idex_aluop  <= ALUOP_NOP;
            idex_alusel <= ALUSEL_NOP;
            idex_a      <= '0;
            idex_b      <= '0;
            idex_waddr  <= '0;
            idex_we     <= 1'b0;
        end else begin
            idex_aluop  <= aluop_i;
            idex_alusel <= alusel_i;
            idex_a      <= rdata1_i;
            idex_b      <= rdata2_i;
            idex_waddr  <= waddr_i;
            idex_we     <= we_i;
        end
    end

    logic [31:0] logic_res;
    logic [31:0] shift_res;
    logic [31:0] arith_res;
    logic        logic_ok;
    logic        shift_ok;
    logic        arith_ok;
    logic [4:0]  shamt;
    logic [31:0] sum;
    logic [31:0] diff;
    logic        add_ovf;
    logic        sub_ovf;
    logic        arith_ovf;

    assign shamt = idex_a[4:0];
    assign sum   = idex_a + idex_b;
    assign diff  = idex_a - idex_b;
    assign add_ovf = (idex_a[31] == idex_b[31]) && (sum[31] != idex_a[31]);
    assign sub_ovf = (idex_a[31] != idex_b[31]) && (diff[31] != idex_a[31]);

    always_comb begin
        logic_res = '0;
        logic_ok  = 1'b1;
        case (idex_aluop)
            ALUOP_AND: logic_res = idex_a & idex_b;
            ALUOP_OR:  logic_res = idex_a | idex_b;
            ALUOP_XOR: logic_res = idex_a ^ idex_b;
            ALUOP_NOR: logic_res = ~(idex_a | idex_b);
            default:   logic_ok  = 1'b0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        shift_ok  = 1'b1;
        case (idex_aluop)
            ALUOP_SLL: shift_res = idex_b << shamt;
            ALUOP_SRL: shift_res = idex_b >> shamt;
            ALUOP_SRA: shift_res = $unsigned($signed(idex_b) >>> shamt);
            default:   shift_ok  = 1'b0;
        endcase
    end

    always_comb begin
        arith_res = '0;
        arith_ok  = 1'b1;
        arith_ovf = 1'b0;
        case (idex_aluop)
            ALUOP_ADD: begin
                arith_res = sum;
                arith_ovf = add_ovf;
            end
            ALUOP_ADDU: arith_res = sum;
            ALUOP_SUB: begin
                arith_res = diff;
                arith_ovf = sub_ovf;
            end
            ALUOP_SUBU: arith_res = diff;
            ALUOP_SLT:  arith_res = {31'b0, $signed(idex_a) < $signed(idex_b)};
            ALUOP_SLTU: arith_res = {31'b0, idex_a < idex_b};
            default:    arith_ok  = 1'b0;
        endcase
    end

    logic [31:0] result;
    logic        known;
    logic        ovf;

    // An aluop outside the class named by alusel counts as unknown.
    always_comb begin
        result = '0;
        known  = 1'b0;
        ovf    = 1'b0;
        case (idex_alusel)
            ALUSEL_LOGIC: begin
                known  = logic_ok;
                result = logic_res;
            end
            ALUSEL_SHIFT: begin
                known  = shift_ok;
                result = shift_res;
            end
            ALUSEL_ARITH: begin
                known  = arith_ok;
                result = arith_res;
                ovf    = arith_ovf;
            end
            default: begin
                known  = 1'b0;
                result = '0;
            end
        endcase
    end

    assign ex_waddr_o = idex_waddr;
    assign ex_wdata_o = result;
    assign ex_we_o    = idex_we && known && !ovf;

    always_ff @(posedge clk) begin
        if (rst || ex_stall_i) begin
            mem_waddr_o <= '0;
            mem_we_o    <= 1'b0;
            mem_wdata_o <= '0;
            ovf_o       <= 1'b0;
        end else begin
            mem_waddr_o <= ex_waddr_o;
            mem_we_o    <= ex_we_o;
            mem_wdata_o <= ex_wdata_o;
            ovf_o       <= ovf && idex_we;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases plus random stream checked against an
// instruction-level reference model of the execute stage.
module tb_ex_stage;

    localparam logic [2:0] S_NOP = 3'b000, S_LOG = 3'b001, S_SHF = 3'b010, S_ARI = 3'b100;
    localparam logic [7:0] O_NOP = 8'h00, O_AND = 8'h24, O_OR = 8'h25, O_XOR = 8'h26,
                           O_NOR = 8'h27, O_SLL = 8'h7C, O_SRL = 8'h02, O_SRA = 8'h03,
                           O_ADD = 8'h20, O_ADDU = 8'h21, O_SUB = 8'h22, O_SUBU = 8'h23,
                           O_SLT = 8'h2A, O_SLTU = 8'h2B;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wa;
        logic        we;
    } inst_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] rdata1_i, rdata2_i;
    logic [4:0]  waddr_i;
    logic        we_i, id_stall_i, ex_stall_i;
    logic [4:0]  ex_waddr_o, mem_waddr_o;
    logic        ex_we_o, mem_we_o, ovf_o;
    logic [31:0] ex_wdata_o, mem_wdata_o;

    int n_vec  = 0;
    int n_miss = 0;

    inst_t       cur;
    logic [4:0]  m_wa;
    logic        m_we;
    logic [31:0] m_wd;
    logic        m_ovf;

    ex_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .rdata1_i(rdata1_i), .rdata2_i(rdata2_i), .waddr_i(waddr_i), .we_i(we_i),
        .id_stall_i(id_stall_i), .ex_stall_i(ex_stall_i),
        .ex_waddr_o(ex_waddr_o), .ex_we_o(ex_we_o), .ex_wdata_o(ex_wdata_o),
        .mem_waddr_o(mem_waddr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
        .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Instruction semantics from the ISA: result, write-enable, overflow flag.
    function automatic void exec(input inst_t i, output logic [31:0] r, output logic we,
                                 output logic ov);
        logic [2:0] cls;
        longint     sa, sb, s;
        sa = longint'($signed(i.a));
        sb = longint'($signed(i.b));
        r = 0; ov = 0; cls = S_NOP;
        case (i.op)
            O_AND:  begin cls = S_LOG; r = i.a & i.b; end
            O_OR:   begin cls = S_LOG; r = i.a | i.b; end
            O_XOR:  begin cls = S_LOG; r = i.a ^ i.b; end
            O_NOR:  begin cls = S_LOG; r = ~(i.a | i.b); end
            O_SLL:  begin cls = S_SHF; r = i.b << i.a[4:0]; end
            O_SRL:  begin cls = S_SHF; r = i.b >> i.a[4:0]; end
            O_SRA:  begin cls = S_SHF; r = 32'(sb >>> i.a[4:0]); end
            O_ADD:  begin cls = S_ARI; s = sa + sb; r = 32'(s);
                          ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            O_ADDU: begin cls = S_ARI; r = 32'(sa + sb); end
            O_SUB:  begin cls = S_ARI; s = sa - sb; r = 32'(s);
                          ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            O_SUBU: begin cls = S_ARI; r = 32'(sa - sb); end
            O_SLT:  begin cls = S_ARI; r = (sa < sb) ? 1 : 0; end
            O_SLTU: begin cls = S_ARI; r = (i.a < i.b) ? 1 : 0; end
            default: cls = S_NOP;
        endcase
        if (cls == S_NOP || cls != i.sel) begin
            r = 0; ov = 0; we = 0;
        end else begin
            we = i.we && !ov;
            ov = ov && i.we;
        end
    endfunction

    function automatic inst_t bubble();
        inst_t b;
        b.op = O_NOP; b.sel = S_NOP; b.a = 0; b.b = 0; b.wa = 0; b.we = 0;
        return b;
    endfunction

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wa, input logic we,
                         input logic ids, input logic exs, input logic r);
        aluop_i = op; alusel_i = sel; rdata1_i = a; rdata2_i = b;
        waddr_i = wa; we_i = we; id_stall_i = ids; ex_stall_i = exs; rst = r;
    endtask

    // One clock: advance the model with the pipeline's update rules, then compare.
    task automatic tick();
        logic [31:0] r;
        logic        w, o;
        inst_t       nxt;
        @(posedge clk);
        nxt.op = aluop_i; nxt.sel = alusel_i; nxt.a = rdata1_i; nxt.b = rdata2_i;
        nxt.wa = waddr_i; nxt.we = we_i;
        if (rst) begin
            m_wa = 0; m_we = 0; m_wd = 0; m_ovf = 0;
            cur = bubble();
        end else if (ex_stall_i) begin
            m_wa = 0; m_we = 0; m_wd = 0; m_ovf = 0;
        end else begin
            exec(cur, r, w, o);
            m_wa = cur.wa; m_we = w; m_wd = r; m_ovf = o;
            cur = id_stall_i ? bubble() : nxt;
        end
        #1;
        exec(cur, r, w, o);
        check("ex_waddr", 32'(ex_waddr_o), 32'(cur.wa));
        check("ex_we", 32'(ex_we_o), 32'(w));
        check("ex_wdata", ex_wdata_o, r);
        check("mem_waddr", 32'(mem_waddr_o), 32'(m_wa));
        check("mem_we", 32'(mem_we_o), 32'(m_we));
        check("mem_wdata", mem_wdata_o, m_wd);
        check("ovf", 32'(ovf_o), 32'(m_ovf));
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [7:0] ops [13] = '{O_AND, O_OR, O_XOR, O_NOR, O_SLL, O_SRL, O_SRA,
                             O_ADD, O_ADDU, O_SUB, O_SUBU, O_SLT, O_SLTU};
    logic [2:0] sels [13] = '{S_LOG, S_LOG, S_LOG, S_LOG, S_SHF, S_SHF, S_SHF,
                              S_ARI, S_ARI, S_ARI, S_ARI, S_ARI, S_ARI};

    initial begin
        cur = bubble();
        m_wa = 0; m_we = 0; m_wd = 0; m_ovf = 0;
        drive(O_ADDU, S_ARI, 32'h1234, 32'h1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        check("rst_ex_we", 32'(ex_we_o), 0);
        check("rst_mem_we", 32'(mem_we_o), 0);
        check("rst_ovf", 32'(ovf_o), 0);

        drive(O_ADDU, S_ARI, 32'hFFFF_FFFF, 32'h1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("addu_ex_wdata", ex_wdata_o, 32'h0);
        check("addu_ex_we", 32'(ex_we_o), 1);
        drive(O_ADD, S_ARI, 32'h7FFF_FFFF, 32'h1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("addu_mem_wdata", mem_wdata_o, 32'h0);
        check("addu_mem_waddr", 32'(mem_waddr_o), 8);
        check("add_ovf_wdata", ex_wdata_o, 32'h8000_0000);
        check("add_ovf_we", 32'(ex_we_o), 0);
        drive(O_SRA, S_SHF, 32'd4, 32'h8000_0000, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("add_ovf_pulse", 32'(ovf_o), 1);
        check("add_ovf_mem_we", 32'(mem_we_o), 0);
        check("sra4", ex_wdata_o, 32'hF800_0000);
        drive(O_SRL, S_SHF, 32'd4, 32'h8000_0000, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("ovf_one_cycle", 32'(ovf_o), 0);
        check("srl4", ex_wdata_o, 32'h0800_0000);
        drive(O_SLL, S_SHF, 32'd0, 32'h8000_0000, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("sll0", ex_wdata_o, 32'h8000_0000);
        drive(O_SLT, S_ARI, 32'hFFFF_FFFF, 32'h1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("slt", ex_wdata_o, 32'h1);
        drive(O_SLTU, S_ARI, 32'hFFFF_FFFF, 32'h1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("sltu", ex_wdata_o, 32'h0);

        drive(O_OR, S_LOG, 32'h00F0, 32'h0F00, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(O_AND, S_LOG, 32'hFFFF, 32'hFFFF, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("stall_held", ex_wdata_o, 32'h0FF0);
            check("stall_mem_we", 32'(mem_we_o), 0);
        end
        drive(O_AND, S_LOG, 32'hFFFF, 32'h00FF, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("stall_retire_wdata", mem_wdata_o, 32'h0FF0);
        check("stall_retire_we", 32'(mem_we_o), 1);

        drive(O_XOR, S_LOG, 32'hF, 32'h1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("bubble_we", 32'(ex_we_o), 0);
        drive(O_XOR, S_LOG, 32'hF, 32'h1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("after_bubble_we", 32'(ex_we_o), 1);
        check("bubble_mem_we", 32'(mem_we_o), 0);
        drive(O_NOP, S_NOP, 0, 0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("rst_discard_mem_we", 32'(mem_we_o), 0);
        drive(O_NOP, S_NOP, 0, 0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("rst_discard_mem_we2", 32'(mem_we_o), 0);

        for (int n = 0; n < 600; n++) begin
            int         k;
            logic [2:0] sel;
            k = $urandom_range(0, 12);
            sel = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : sels[k];
            drive(($urandom_range(0, 19) == 0) ? 8'($urandom) : ops[k], sel,
                  pick_val(), pick_val(), 5'($urandom), 1'($urandom_range(0, 7) != 0),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 49) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
